// File: rtl/fft_bfly_stage_pkg.sv
// ---------------------------------------------------------------------------
// fft_bfly_stage_pkg : shared FFT word size, Q-format limits, complex packing
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fft_bfly_stage_pkg;

  localparam int FFT_WORD = 16;
  localparam int FFT_MAXW = 32;

  typedef logic signed [FFT_MAXW-1:0]   qword_t;
  typedef logic        [2*FFT_MAXW-1:0] qpair_t;

  function automatic qword_t q_max(input int w);
    qword_t one = qword_t'(1);
    return (one <<< (w - 1)) - one;
  endfunction

  function automatic qword_t q_min(input int w);
    qword_t one = qword_t'(1);
    return -(one <<< (w - 1));
  endfunction

  // Components are packed {re, im}, each w bits wide; results are sign-extended.
  function automatic qword_t cplx_re(input qpair_t x, input int w);
    qword_t r = qword_t'(x >> w);
    return (r <<< (FFT_MAXW - w)) >>> (FFT_MAXW - w);
  endfunction

  function automatic qword_t cplx_im(input qpair_t x, input int w);
    qword_t r = qword_t'(x);
    return (r <<< (FFT_MAXW - w)) >>> (FFT_MAXW - w);
  endfunction

  function automatic qpair_t cplx_pack(input qword_t re, input qword_t im, input int w);
    qpair_t m = (qpair_t'(1) << w) - qpair_t'(1);
    return ((qpair_t'(re) & m) << w) | (qpair_t'(im) & m);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_bfly_stage_if.sv
// ---------------------------------------------------------------------------
// fft_bfly_stage_if : butterfly stage operand / result bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fft_bfly_stage_if
  import fft_bfly_stage_pkg::*;
#(
  parameter int WORD = FFT_WORD
) ();

  logic              in_valid;
  logic [2*WORD-1:0] a_in;
  logic [2*WORD-1:0] p_in;
  logic              ovf_clr;
  logic              out_valid;
  logic [2*WORD-1:0] y0;
  logic [2*WORD-1:0] y1;
  logic              out_last;
  logic              ovf;

  modport master (
    output in_valid, a_in, p_in, ovf_clr,
    input  out_valid, y0, y1, out_last, ovf
  );

  modport slave (
    input  in_valid, a_in, p_in, ovf_clr,
    output out_valid, y0, y1, out_last, ovf
  );

endinterface

`default_nettype wire

// File: rtl/fft_sat_addsub.sv
// ---------------------------------------------------------------------------
// fft_sat_addsub : one-component sum/difference, halved or saturated
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fft_sat_addsub
  import fft_bfly_stage_pkg::*;
#(
  parameter int WORD  = FFT_WORD,
  parameter int SCALE = 1
) (
  input  logic signed [WORD-1:0] i_a,
  input  logic signed [WORD-1:0] i_b,
  output logic signed [WORD-1:0] o_sum,
  output logic signed [WORD-1:0] o_dif,
  output logic                   o_sat
);

  localparam logic signed [WORD-1:0] C_MAX = WORD'(q_max(WORD));
  localparam logic signed [WORD-1:0] C_MIN = WORD'(q_min(WORD));

  logic signed [WORD:0]   w_sum;
  logic signed [WORD:0]   w_dif;
  logic                   w_ovs;
  logic                   w_ovd;
  logic signed [WORD-1:0] w_sum_sat;
  logic signed [WORD-1:0] w_dif_sat;

  assign w_sum = {i_a[WORD-1], i_a} + {i_b[WORD-1], i_b};
  assign w_dif = {i_a[WORD-1], i_a} - {i_b[WORD-1], i_b};

  // Top two bits disagree exactly when the result leaves the WORD-bit range.
  assign w_ovs = w_sum[WORD] ^ w_sum[WORD-1];
  assign w_ovd = w_dif[WORD] ^ w_dif[WORD-1];

  assign w_sum_sat = w_ovs ? (w_sum[WORD] ? C_MIN : C_MAX) : w_sum[WORD-1:0];
  assign w_dif_sat = w_ovd ? (w_dif[WORD] ? C_MIN : C_MAX) : w_dif[WORD-1:0];

  assign o_sum = (SCALE != 0) ? w_sum[WORD:1] : w_sum_sat;
  assign o_dif = (SCALE != 0) ? w_dif[WORD:1] : w_dif_sat;
  assign o_sat = (SCALE == 0) && (w_ovs || w_ovd);

endmodule

`default_nettype wire

// File: rtl/fft_bfly_stage.sv
// ---------------------------------------------------------------------------
// fft_bfly_stage : radix-2 butterfly stage with frame marking and ovf flag
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fft_bfly_stage
  import fft_bfly_stage_pkg::*;
#(
  parameter int WORD     = FFT_WORD,
  parameter int MULT_LAT = 2,
  parameter int POINTS   = 32,
  parameter int SCALE    = 1
) (
  input logic             clk,
  input logic             reset,
  fft_bfly_stage_if.slave bus
);

  localparam int            CW     = $clog2(POINTS / 2);
  localparam logic [CW-1:0] C_LAST = CW'(POINTS / 2 - 1);

  logic [MULT_LAT-1:0][2*WORD-1:0] r_a_dly;
  logic [MULT_LAT-1:0]             r_v_dly;

  // Top operand rides alongside the multiplier so it meets its product on p_in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_dly <= '0;
      r_v_dly <= '0;
    end else begin
      r_a_dly[0] <= bus.a_in;
      r_v_dly[0] <= bus.in_valid;
      for (int k = 1; k < MULT_LAT; k++) begin
        r_a_dly[k] <= r_a_dly[k-1];
        r_v_dly[k] <= r_v_dly[k-1];
      end
    end
  end

  logic [2*WORD-1:0]      w_a;
  logic                   w_v;
  logic signed [WORD-1:0] w_a_c [2];
  logic signed [WORD-1:0] w_p_c [2];
  logic signed [WORD-1:0] w_s_c [2];
  logic signed [WORD-1:0] w_d_c [2];
  logic [1:0]             w_sat;
  logic [2*WORD-1:0]      w_y0;
  logic [2*WORD-1:0]      w_y1;

  assign w_a = r_a_dly[MULT_LAT-1];
  assign w_v = r_v_dly[MULT_LAT-1];

  // Index 1 holds the real component, index 0 the imaginary one.
  assign w_a_c[1] = WORD'(cplx_re(qpair_t'(w_a), WORD));
  assign w_a_c[0] = WORD'(cplx_im(qpair_t'(w_a), WORD));
  assign w_p_c[1] = WORD'(cplx_re(qpair_t'(bus.p_in), WORD));
  assign w_p_c[0] = WORD'(cplx_im(qpair_t'(bus.p_in), WORD));

  for (genvar c = 0; c < 2; c++) begin : g_comp
    fft_sat_addsub #(
      .WORD  (WORD),
      .SCALE (SCALE)
    ) u_addsub (
      .i_a   (w_a_c[c]),
      .i_b   (w_p_c[c]),
      .o_sum (w_s_c[c]),
      .o_dif (w_d_c[c]),
      .o_sat (w_sat[c])
    );
  end

  assign w_y0 = (2*WORD)'(cplx_pack(qword_t'(w_s_c[1]), qword_t'(w_s_c[0]), WORD));
  assign w_y1 = (2*WORD)'(cplx_pack(qword_t'(w_d_c[1]), qword_t'(w_d_c[0]), WORD));

  logic [2*WORD-1:0] r_y0;
  logic [2*WORD-1:0] r_y1;
  logic              r_ov;
  logic              r_last;
  logic              r_ovf;
  logic [CW-1:0]     r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_y0   <= '0;
      r_y1   <= '0;
      r_ov   <= 1'b0;
      r_last <= 1'b0;
      r_ovf  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_ov   <= w_v;
      r_last <= w_v && (r_cnt == C_LAST);
      if (w_v) begin
        r_y0  <= w_y0;
        r_y1  <= w_y1;
        r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
      end
      // A fresh saturation outranks a simultaneous clear.
      if (w_v && (|w_sat)) begin
        r_ovf <= 1'b1;
      end else if (bus.ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_ov;
  assign bus.y0        = r_y0;
  assign bus.y1        = r_y1;
  assign bus.out_last  = r_last;
  assign bus.ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_fft_bfly_stage.sv
// ---------------------------------------------------------------------------
// tb_fft_bfly_stage : directed checks of a scaling and a saturating stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fft_bfly_stage;
  import fft_bfly_stage_pkg::*;

  localparam int TW   = 16;
  localparam int TML  = 2;
  localparam int TPTS = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fft_bfly_stage_if #(.WORD(TW)) bus_s ();
  fft_bfly_stage_if #(.WORD(TW)) bus_z ();

  fft_bfly_stage #(.WORD(TW), .MULT_LAT(TML), .POINTS(TPTS), .SCALE(1)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  fft_bfly_stage #(.WORD(TW), .MULT_LAT(TML), .POINTS(TPTS), .SCALE(0)) dut_z (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_z)
  );

  logic        v_in   = 1'b0;
  logic        clr_in = 1'b0;
  logic [31:0] a_drv  = '0;
  logic [31:0] p_next = '0;
  logic [31:0] p_d1;
  logic [31:0] p_d2;

  // Stand-in for the complex multiplier: product trails its operand by TML cycles.
  always_ff @(posedge clk) begin
    p_d1 <= p_next;
    p_d2 <= p_d1;
  end

  assign bus_s.in_valid = v_in;
  assign bus_s.a_in     = a_drv;
  assign bus_s.p_in     = p_d2;
  assign bus_s.ovf_clr  = clr_in;
  assign bus_z.in_valid = v_in;
  assign bus_z.a_in     = a_drv;
  assign bus_z.p_in     = p_d2;
  assign bus_z.ovf_clr  = clr_in;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, want);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] p, input logic clr);
    v_in   = v;
    a_drv  = a;
    p_next = p;
    clr_in = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    drive(1'b0, '0, '0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int n, input int gap_at, input int gap_len,
                           input logic [7:0] want_mask, input int want_cnt);
    int         issued   = 0;
    int         gapc     = 0;
    int         outs_s   = 0;
    int         outs_z   = 0;
    int         stray    = 0;
    int         data_bad = 0;
    logic [7:0] mask_s   = '0;
    logic [7:0] mask_z   = '0;
    for (int c = 0; c < n + gap_len + TML + 4; c++) begin
      logic        v;
      logic [15:0] re;
      v  = 1'b0;
      re = 16'(issued * 256);
      if (issued < n) begin
        if (issued == gap_at && gapc < gap_len) gapc++;
        else v = 1'b1;
      end
      drive(v, {re, 16'h0000}, 32'h0, 1'b0);
      if (v) issued++;
      if (bus_s.out_valid) begin
        if (outs_s < 8) begin
          mask_s[outs_s] = bus_s.out_last;
          if (bus_s.y0 !== {16'(outs_s * 128), 16'h0000}) data_bad++;
        end
        outs_s++;
      end else if (bus_s.out_last) stray++;
      if (bus_z.out_valid) begin
        if (outs_z < 8) mask_z[outs_z] = bus_z.out_last;
        outs_z++;
      end else if (bus_z.out_last) stray++;
    end
    check_val({tag, "_mask_s"}, mask_s, want_mask);
    check_val({tag, "_mask_z"}, mask_z, want_mask);
    check_val({tag, "_cnt_s"}, outs_s, want_cnt);
    check_val({tag, "_cnt_z"}, outs_z, want_cnt);
    check_val({tag, "_stray_last"}, stray, 0);
    check_val({tag, "_data_s"}, data_bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    drive(1'b0, '0, '0, 1'b0);
    drive(1'b0, '0, '0, 1'b0);
    check_val("rst_ov_s",   bus_s.out_valid, 0);
    check_val("rst_y0_s",   bus_s.y0,        0);
    check_val("rst_y1_s",   bus_s.y1,        0);
    check_val("rst_last_s", bus_s.out_last,  0);
    check_val("rst_ov_z",   bus_z.out_valid, 0);
    check_val("rst_ovf_z",  bus_z.ovf,       0);
    reset = 1'b0;

    // Basic arithmetic and latency
    drive(1'b1, 32'h4000_0000, 32'h2000_1000, 1'b0);
    drive(1'b0, '0, '0, 1'b0);
    check_val("lat_early_ov", bus_s.out_valid, 0);
    drive(1'b0, '0, '0, 1'b0);
    check_val("scl_ov",   bus_s.out_valid, 1);
    check_val("scl_y0",   bus_s.y0,  32'h3000_0800);
    check_val("scl_y1",   bus_s.y1,  32'h1000_F800);
    check_val("sat_y0",   bus_z.y0,  32'h6000_1000);
    check_val("sat_y1",   bus_z.y1,  32'h2000_F000);
    check_val("sat_ovf0", bus_z.ovf, 0);
    drive(1'b0, '0, '0, 1'b0);
    check_val("idle_ov",   bus_s.out_valid, 0);
    check_val("hold_y0",   bus_s.y0, 32'h3000_0800);
    check_val("hold_y1",   bus_s.y1, 32'h1000_F800);

    // Saturation, set-beats-clear, then clear
    do_reset();
    drive(1'b1, 32'h7000_0000, 32'h2000_0000, 1'b0);
    drive(1'b1, 32'h8000_0000, 32'h0001_0000, 1'b0);
    drive(1'b0, '0, '0, 1'b0);
    check_val("satp_y0",  bus_z.y0,  32'h7FFF_0000);
    check_val("satp_y1",  bus_z.y1,  32'h5000_0000);
    check_val("satp_ovf", bus_z.ovf, 1);
    check_val("sclp_y0",  bus_s.y0,  32'h4800_0000);
    check_val("sclp_y1",  bus_s.y1,  32'h2800_0000);
    check_val("scl_ovf",  bus_s.ovf, 0);
    drive(1'b0, '0, '0, 1'b1);
    check_val("satn_y0",       bus_z.y0,  32'h8001_0000);
    check_val("satn_y1",       bus_z.y1,  32'h8000_0000);
    check_val("ovf_set_wins",  bus_z.ovf, 1);
    check_val("scln_y0",       bus_s.y0,  32'hC000_0000);
    check_val("scln_y1",       bus_s.y1,  32'hBFFF_0000);
    drive(1'b0, '0, '0, 1'b1);
    check_val("ovf_cleared",   bus_z.ovf, 0);
    drive(1'b0, '0, '0, 1'b0);

    // Frame marking with a gap
    do_reset();
    run_frame("frame", 8, 3, 3, 8'h88, 8);

    // Reset mid-frame
    do_reset();
    drive(1'b1, 32'h7000_0000, 32'h2000_0000, 1'b0);
    drive(1'b1, 32'h0100_0000, 32'h0, 1'b0);
    drive(1'b1, 32'h0200_0000, 32'h0, 1'b0);
    drive(1'b0, '0, '0, 1'b0);
    check_val("mid_ov_pre",  bus_s.out_valid, 1);
    check_val("mid_ovf_pre", bus_z.ovf, 1);
    reset = 1'b1;
    #1;
    check_val("mid_ov_s",  bus_s.out_valid, 0);
    check_val("mid_ov_z",  bus_z.out_valid, 0);
    check_val("mid_ovf_z", bus_z.ovf, 0);
    check_val("mid_y0_s",  bus_s.y0, 0);
    check_val("mid_y0_z",  bus_z.y0, 0);
    drive(1'b0, '0, '0, 1'b0);
    reset = 1'b0;
    run_frame("post_rst", 4, 0, 0, 8'h08, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
